cdc_handshake_tx: RTL and testbench
===================================

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2 (minimum 2): flip-flop stages on the tx_ack synchronizer.
REQ-003 SHALL have parameter TIMEOUT, default 1024: cycles allowed in REQ_HI before err sets; 0 disables the timeout.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
 - clk  input  1  sole clock; all state on its rising edge.
 - rst_n  input  1  asynchronous active-low reset.
 - in_valid  input  1  source has a word.
 - in_data  input  WIDTH  word to send.
 - in_ready  output  1  block can accept a word.
 - tx_req  output  1  4-phase request to the destination domain, registered.
 - tx_data  output  WIDTH  word held for the destination, registered.
 - tx_ack  input  1  4-phase acknowledge from the destination domain, asynchronous to clk.
 - done  output  1  one-cycle pulse when a transfer completes.
 - err  output  1  sticky timeout flag.
 - err_clr  input  1  clears err.

Function
REQ-005 SHALL pass tx_ack through a SYNC_STAGES-deep flip-flop chain; ack_s (last stage) SHALL be the only form of tx_ack used by the FSM.
REQ-006 SHALL implement the FSM states IDLE, REQ_HI and REQ_LO.
REQ-007 in_ready SHALL equal (state==IDLE) and SHALL be 0 while rst_n is low.
REQ-008 When in IDLE with in_valid=1, the block SHALL capture in_data into tx_data, set tx_req=1 and enter REQ_HI; both outputs change on the same edge.
REQ-009 tx_data SHALL NOT change in REQ_HI or REQ_LO.
REQ-010 In REQ_HI with ack_s=1, the block SHALL clear tx_req and enter REQ_LO.
REQ-011 In REQ_LO with ack_s=0, the block SHALL enter IDLE and pulse done=1 for exactly that cycle.
REQ-012 done SHALL be 0 in all other cycles.
REQ-013 Minimum round trip with an immediately responding destination:
 - accept to done is 2*SYNC_STAGES+2 cycles, excluding destination latency.
 - back-to-back accepts SHALL be possible, since in_ready is 1 in the cycle after done.
REQ-014 If ack_s=1 while the FSM is in IDLE (stale acknowledge), in_ready SHALL be 0 and the FSM SHALL stay in IDLE until ack_s=0.
REQ-015 Timeout counter behaviour:
 - SHALL be ceil(log2(TIMEOUT+1)) bits wide.
 - SHALL clear on entry to REQ_HI and increment each cycle in REQ_HI.
 - SHALL saturate at TIMEOUT.
 - SHALL set err when it reaches TIMEOUT.
REQ-016 A timeout SHALL NOT abort the handshake: tx_req stays 1 and the FSM keeps waiting.
REQ-017 err SHALL be cleared only by err_clr or reset. If err_clr and a timeout-set occur in the same cycle, the set SHALL win.
REQ-018 With TIMEOUT=0, err SHALL remain 0.

Reset
REQ-019 While rst_n=0, all of the following SHALL hold asynchronously:
 - state=IDLE, tx_req=0, tx_data=0.
 - done=0, err=0, in_ready=0.
 - timeout counter=0 and all synchronizer stages=0.
REQ-020 If reset asserts mid-transfer, tx_req SHALL drop immediately, and the block SHALL NOT resume the interrupted transfer after reset.
REQ-021 If reset releases while tx_ack=1, REQ-014 governs, and no word is accepted until ack_s=0.

Verification (WIDTH=8, SYNC_STAGES=2, TIMEOUT=16)
REQ-022 Single transfer:
 - stimulus: in_data=0xA5 accepted at cycle 0; destination model raises tx_ack 1 cycle after seeing tx_req and drops it 1 cycle after tx_req falls.
 - response: tx_req=1 and tx_data=0xA5 from cycle 1; tx_req=0 at cycle 4; one done pulse; in_ready back to 1 afterward.
REQ-023 Back-to-back transfers:
 - stimulus: 0x01, 0x02, 0x03 presented with in_valid held high.
 - response: each word appears on tx_data in order; tx_data is stable across each REQ_HI/REQ_LO window; exactly 3 done pulses.
REQ-024 Timeout:
 - stimulus: tx_ack held at 0 after an accept.
 - response: err=1 exactly 16 cycles after entry to REQ_HI; tx_req stays 1.
 - then: raising tx_ack completes the transfer normally with err still 1; err_clr returns err to 0.
REQ-025 Reset mid-transfer:
 - stimulus: rst_n=0 during REQ_HI.
 - response: tx_req=0 and tx_data=0 without waiting for a clk edge.
 - stimulus: release reset with tx_ack=1.
 - response: in_ready=0 until 2 cycles after tx_ack falls.
REQ-026 Stale acknowledge:
 - stimulus: tx_ack pulsed high while in IDLE.
 - response: in_ready=0 while ack_s=1; no spurious tx_req or done pulse.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source side of a 4-phase req/ack handshake carrying a held data word into an
// asynchronous destination domain, with an optional REQ_HI timeout flag.
module cdc_handshake_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ack,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_HIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_boot;
    logic                   r_tx_req;
    logic [WIDTH-1:0]       r_tx_data;
    logic [CW-1:0]          r_cnt;
    logic                   r_err;
    logic                   w_ack_s;
    logic                   w_primed;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_to_hit;

    // r_boot fills in lock-step with r_sync, so ack_s is trusted only once the
    // chain holds a real sample of tx_ack taken after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_boot <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tx_ack};
            r_boot <= {r_boot[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_ack_s  = r_sync[SYNC_STAGES-1];
    assign w_primed = r_boot[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_primed && !w_ack_s && in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = REQ_HI;
                end
            end
            REQ_HI: begin
                if (w_ack_s) w_state_nxt = REQ_LO;
            end
            REQ_LO: begin
                if (!w_ack_s) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Fires once, on the cycle the counter steps onto TIMEOUT.
    assign w_to_hit = (TIMEOUT != 0) && (r_state == REQ_HI) && (r_cnt == TO_HIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_tx_req  <= 1'b0;
            r_tx_data <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tx_req <= (w_state_nxt == REQ_HI);
            if (w_accept) r_tx_data <= in_data;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == REQ_HI && r_cnt != TO_MAX)
                r_cnt <= r_cnt + 1'b1;
            if (w_to_hit)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

    assign in_ready = (r_state == IDLE) && w_primed && !w_ack_s;
    assign tx_req   = r_tx_req;
    assign tx_data  = r_tx_data;
    assign done     = w_done;
    assign err      = r_err;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (WIDTH=8, SYNC_STAGES=2, TIMEOUT=16):
// a per-cycle vector table plus hand sequences for multi-cycle corners.
module tb_cdc_handshake_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       done;
    logic       err;
    logic       err_clr;
    logic       dest_auto = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .tx_req(tx_req), .tx_data(tx_data),
        .tx_ack(tx_ack), .done(done), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Destination model: acknowledge mirrors the request half a cycle later.
    always @(negedge clk) if (dest_auto) tx_ack = tx_req;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ack;
        logic       clr;
        logic       rdy;
        logic       req;
        logic [7:0] data;
        logic       dn;
        logic       er;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int         ndone, nacc, extra, stab_err, b2b_err;
        logic [7:0] cur;
        logic       acc, prev_done, got;

        //            v   d      ack clr  rdy req data   dn er
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        // stale acknowledge while idle, with a word offered during the blocked window
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; tx_ack = 1'b0; err_clr = 1'b0;
        #3;
        chk("rst.in_ready", in_ready, 0);
        chk("rst.tx_req",   tx_req,   0);
        chk("rst.tx_data",  tx_data,  0);
        chk("rst.done",     done,     0);
        chk("rst.err",      err,      0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            in_valid = tbl[i].v; in_data = tbl[i].d; tx_ack = tbl[i].ack; err_clr = tbl[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("vec%0d.tx_req", i),   tx_req,   tbl[i].req);
            chk($sformatf("vec%0d.tx_data", i),  tx_data,  tbl[i].data);
            chk($sformatf("vec%0d.done", i),     done,     tbl[i].dn);
            chk($sformatf("vec%0d.err", i),      err,      tbl[i].er);
        end

        // back-to-back: 01, 02, 03 with in_valid held high
        @(posedge clk);
        #1 in_valid = 1'b1; in_data = 8'h01; dest_auto = 1'b1;
        ndone = 0; nacc = 0; stab_err = 0; b2b_err = 0; prev_done = 1'b0; cur = 8'h00;
        for (int c = 0; c < 200 && ndone < 3; c++) begin
            @(negedge clk);
            acc = in_ready && in_valid;
            if (prev_done && !in_ready) b2b_err++;
            if (nacc > 0 && !in_ready && tx_data !== cur) stab_err++;
            prev_done = done;
            if (done) begin
                chk($sformatf("b2b.word%0d", ndone), tx_data, 8'h01 + 8'(ndone));
                ndone++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                nacc++;
                cur = in_data;
                if (nacc == 3) in_valid = 1'b0;
                else in_data = in_data + 8'h01;
            end
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("b2b.done_count", ndone + extra, 3);
        chk("b2b.stable",     stab_err, 0);
        chk("b2b.ready_after_done", b2b_err, 0);

        // timeout: no acknowledge after accept
        @(posedge clk);
        #1 dest_auto = 1'b0; tx_ack = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) chk("to.err_before", err, 0);
            if (k == 17) begin
                chk("to.err_set", err, 1);
                chk("to.req_held", tx_req, 1);
            end
            if (k < 17) @(posedge clk);
        end
        dest_auto = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                chk("to.err_sticky", err, 1);
                chk("to.data", tx_data, 8'h5A);
            end
        end
        chk("to.completed", got, 1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("to.err_cleared", err, 0);

        // reset during REQ_HI, released with tx_ack still high
        @(posedge clk);
        #1 dest_auto = 1'b0; tx_ack = 1'b0; in_valid = 1'b1; in_data = 8'hC3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("rmt.req_before", tx_req, 1);
        #2 rst_n = 1'b0; tx_ack = 1'b1;
        #1;
        chk("rmt.req_async",   tx_req,   0);
        chk("rmt.data_async",  tx_data,  0);
        chk("rmt.ready_async", in_ready, 0);
        chk("rmt.done_async",  done,     0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        stab_err = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ready || tx_req) stab_err++;
        end
        chk("rmt.blocked_while_ack", stab_err, 0);
        @(posedge clk);
        #1 tx_ack = 1'b0;
        @(negedge clk);
        chk("rmt.ready_c0", in_ready, 0);
        @(negedge clk);
        chk("rmt.ready_c1", in_ready, 0);
        @(negedge clk);
        chk("rmt.ready_c2", in_ready, 1);
        chk("rmt.no_resume", tx_req, 0);
        chk("rmt.data_zero", tx_data, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
